spi_master_ctrl: RTL and testbench

Host-side SPI master that turns single-byte register-access requests into serial frames for the SPI slave controller and its 32x8 register memory. It drives the frame header of 2 mode bits and 5 address bits, then either shifts out a write byte or captures a read byte from MISO. It runs on the same clock as the slave, one bit per cycle, and returns read data with a done pulse.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_master_ctrl.sv | 95 +++++++++
 tb/tb_spi_master_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame constants and state encoding for the master and slave controllers
// Contents: frame mode codes, header/data/address widths, FSM state constants.
package spi_pkg;
   localparam logic [1:0] SPI_MODE_WR     = 2'b10;
   localparam logic [1:0] SPI_MODE_RD     = 2'b00;
   localparam logic [1:0] SPI_MODE_RD_INC = 2'b01;
   localparam int SPI_HDR_BITS  = 7;
   localparam int SPI_DATA_BITS = 8;
   localparam int SPI_ADDR_W    = 5;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SEL   = 3'd1;
   localparam logic [2:0] ST_HDR   = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_TRAIL = 3'd4;
   localparam logic [2:0] ST_GAP   = 3'd5;
endpackage

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-byte SPI register-access master (2 mode + 5 address header, 8 data bits)
// Ports: clk, rst (async, active low); start/rw/addr/wdata request; MISO in;
//        MOSI/CS serial out; busy, done pulse, rdata (last read byte).
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  rw,
   input  logic [SPI_ADDR_W-1:0] addr,
   input  logic [7:0]            wdata,
   input  logic                  MISO,
   output logic                  MOSI,
   output logic                  CS,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            rdata
);
   localparam logic [4:0] HDR_END  = 5'(SPI_HDR_BITS - 1);
   localparam logic [4:0] DATA_END = 5'(SPI_HDR_BITS + SPI_DATA_BITS - 1);
   // Read byte arrives on MISO over edges S+11..S+18 (cycle count 10..17)
   localparam logic [4:0] RX_FIRST = 5'd10;
   localparam logic [4:0] CS_END   = 5'd17;
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [14:0] tx_q, tx_d;
   logic [7:0]  rx_q, rx_d, rdata_q, rdata_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [3:0]  gap_q, gap_d;
   logic        rw_q, rw_d, cs_q, cs_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
   logic        shift, gap_end, accept;

   always_comb begin
      shift   = state_q == ST_SEL || state_q == ST_HDR || state_q == ST_DATA;
      gap_end = state_q == ST_GAP && gap_q == GAP_LAST;
      // the last gap edge doubles as an idle edge so a held start restarts with no dead cycle
      accept  = start && (state_q == ST_IDLE || gap_end);
      tx_d    = accept ? {rw ? wdata : 8'h00, addr, rw ? SPI_MODE_WR : SPI_MODE_RD}
              : shift ? tx_q >> 1 : tx_q;
      rw_d    = accept ? rw : rw_q;
      cnt_d   = accept ? 5'd0 : (shift || state_q == ST_TRAIL) ? cnt_q + 5'd1 : cnt_q;
      rx_d    = (cnt_q >= RX_FIRST && cnt_q <= CS_END) ? {MISO, rx_q[7:1]} : rx_q;
      mosi_d  = shift ? tx_q[0] : 1'b0;
      cs_d    = accept ? 1'b0 : (state_q == ST_TRAIL && cnt_q == CS_END) ? 1'b1 : cs_q;
      done_d  = state_q == ST_GAP && gap_q == 4'd0;
      rdata_d = (done_d && !rw_q) ? rx_q : rdata_q;
      gap_d   = (state_q == ST_GAP && !gap_end) ? gap_q + 4'd1 : 4'd0;
      busy_d  = accept ? 1'b1 : gap_end ? 1'b0 : busy_q;
      state_d = accept ? ST_SEL
              : gap_end ? ST_IDLE
              : state_q == ST_SEL ? ST_HDR
              : (state_q == ST_HDR && cnt_q == HDR_END) ? ST_DATA
              : (state_q == ST_DATA && cnt_q == DATA_END) ? ST_TRAIL
              : (state_q == ST_TRAIL && cnt_q == CS_END) ? ST_GAP
              : state_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         rw_q    <= 1'b0;
         cs_q    <= 1'b1;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         rw_q    <= rw_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign MOSI  = mosi_q;
   assign CS    = cs_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;
   logic clk = 1'b0;
   logic rst, start, start5, rw, MISO;
   logic [4:0] addr;
   logic [7:0] wdata;
   logic mosi, cs, busy, done, mosi5, cs5, busy5, done5;
   logic [7:0] rdata, rdata5;
   logic [7:0] mem [32];
   logic [14:0] mosi_v;
   logic [31:0] cs_v, done_v, busy_v;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spi_master_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata), .MISO(MISO),
      .MOSI(mosi), .CS(cs), .busy(busy), .done(done), .rdata(rdata)
   );

   spi_master_ctrl #(.GAP_CYCLES(5)) dut5 (
      .clk(clk), .rst(rst), .start(start5), .rw(rw), .addr(addr), .wdata(wdata), .MISO(MISO),
      .MOSI(mosi5), .CS(cs5), .busy(busy5), .done(done5), .rdata(rdata5)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one frame from edge S (issued here unless pre=1), recording outputs after edges 0..last.
   // m is the byte the modelled slave returns on MISO at edges S+11..S+18.
   task automatic run(input logic pre, input logic r, input logic [4:0] a, input logic [7:0] w,
                      input logic [7:0] m, input int last, input logic hold, input int pa, input int pb);
      mosi_v = '0; cs_v = '0; done_v = '0; busy_v = '0;
      if (!pre) begin
         rw = r; addr = a; wdata = w; start = 1'b1;
         cyc();
      end
      start = hold;
      cs_v[0] = cs; done_v[0] = done; busy_v[0] = busy;
      for (int n = 1; n <= last; n++) begin
         start = hold || n == pa || n == pb;
         MISO = (n >= 11 && n <= 18) ? m[3'(n - 11)] : 1'b0;
         cyc();
         if (n <= 15) mosi_v[4'(n - 1)] = mosi;
         cs_v[5'(n)] = cs; done_v[5'(n)] = done; busy_v[5'(n)] = busy;
      end
      MISO = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      rst = 1'b0; start = 1'b0; start5 = 1'b0; rw = 1'b0; addr = '0; wdata = '0; MISO = 1'b0;
      cyc();
      cyc();
      chk("rst_cs", cs, 1'b1);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_cs5", cs5, 1'b1);
      rst = 1'b1;
      cyc();

      // abort a read mid-frame with async reset
      run(1'b0, 1'b0, 5'h07, 8'h00, 8'hFF, 11, 1'b0, -1, -1);
      chk("pre_abort_cs", cs, 1'b0);
      rst = 1'b0;
      #1;
      chk("abort_cs", cs, 1'b1);
      chk("abort_mosi", mosi, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_rdata", rdata, 8'h00);
      cyc();
      rst = 1'b1;
      cyc();

      // read addr 7, slave holds 0x3C
      mem[7] = 8'h3C;
      run(1'b0, 1'b0, 5'h07, 8'h00, mem[7], 21, 1'b0, -1, -1);
      chk("rd7_mosi", 32'(mosi_v), 32'h001C);
      chk("rd7_cs", cs_v, 32'h3C0000);
      chk("rd7_done", done_v, 32'h080000);
      chk("rd7_busy", busy_v, 32'h0FFFFF);
      chk("rd7_rdata", rdata, 8'h3C);

      // write addr 0x13 = 0xA5
      run(1'b0, 1'b1, 5'h13, 8'hA5, 8'h00, 21, 1'b0, -1, -1);
      mem[5'h13] = 8'hA5;
      chk("wr13_mosi", 32'(mosi_v), 32'h52CE);
      chk("wr13_cs", cs_v, 32'h3C0000);
      chk("wr13_done", done_v, 32'h080000);
      chk("wr13_busy", busy_v, 32'h0FFFFF);
      chk("wr13_rdata_kept", rdata, 8'h3C);

      // back-to-back: write 0x1F=0xFF with start held, then read 0x1F
      run(1'b0, 1'b1, 5'h1F, 8'hFF, 8'h00, 19, 1'b1, -1, -1);
      mem[5'h1F] = 8'hFF;
      chk("b2b_wr_mosi", 32'(mosi_v), 32'h7FFE);
      chk("b2b_wr_cs", cs_v, 32'h0C0000);
      rw = 1'b0;
      cyc();
      chk("b2b_cs_fall_s20", cs, 1'b0);
      chk("b2b_busy_s20", busy, 1'b1);
      run(1'b1, 1'b0, 5'h1F, 8'h00, mem[5'h1F], 21, 1'b0, -1, -1);
      chk("b2b_rd_mosi", 32'(mosi_v), 32'h007C);
      chk("b2b_rd_done", done_v, 32'h080000);
      chk("b2b_rd_rdata", rdata, 8'hFF);

      // stray start pulses while busy are dropped
      run(1'b0, 1'b0, 5'h13, 8'h00, mem[5'h13], 22, 1'b0, 5, 19);
      chk("ign_done", done_v, 32'h080000);
      chk("ign_cs", cs_v, 32'h7C0000);
      chk("ign_busy", busy_v, 32'h0FFFFF);
      chk("ign_rdata", rdata, 8'hA5);

      // GAP_CYCLES=5 instance: busy falls at S+23, start at S+22 ignored
      rw = 1'b1; addr = 5'h02; wdata = 8'h11; start5 = 1'b1;
      cyc();
      start5 = 1'b0;
      cs_v = '0; busy_v = '0; done_v = '0;
      for (int n = 1; n <= 24; n++) begin
         start5 = n == 22;
         cyc();
         cs_v[5'(n)] = cs5; busy_v[5'(n)] = busy5; done_v[5'(n)] = done5;
      end
      start5 = 1'b0;
      chk("gap5_busy", busy_v, 32'h7FFFFE);
      chk("gap5_cs", cs_v, 32'h1FC0000);
      chk("gap5_done", done_v, 32'h080000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
